image_window_streamer: RTL

- Parametrised successor to the image broadcast stage. Scans a rectangular pixel window across every channel plane of an image held in single-port block RAM.
- Features: per-row vertical stride, zero padding, incremental adder-based address generation (no multipliers), and a valid/ready output that tolerates downstream backpressure.
- Sits between the positioner (window and config source) and the issue/allocator stage (pixel consumer).

---
 rtl/image_window_streamer.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/image_window_streamer.sv
// Scans a padded pixel window over every channel plane of an image in single-port RAM
// and streams the pixels through a 2-entry valid/ready buffer.
module image_window_streamer #(
    parameter int COORD_W = 8,
    parameter int CH_W    = 9,
    parameter int DATA_W  = 18,
    parameter int ADDR_W  = 21,
    parameter int PAD_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] image_dim,
    input  logic [PAD_W-1:0]   image_padding,
    input  logic [COORD_W-1:0] x_lo,
    input  logic [COORD_W-1:0] x_hi,
    input  logic [COORD_W-1:0] y_lo,
    input  logic [COORD_W-1:0] y_hi,
    input  logic [1:0]         y_stride,
    input  logic [CH_W-1:0]    z_last,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0]  rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [CH_W-1:0]    out_z,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE_ERR} state_t;

    typedef struct packed {
        logic               last;
        logic [CH_W-1:0]    z;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
        logic [DATA_W-1:0]  data;
    } entry_t;

    state_t state_reg, state_next;

    logic [COORD_W-1:0] dim_reg, x_lo_reg, x_hi_reg, y_lo_reg, y_hi_reg;
    logic [PAD_W-1:0]   pad_reg;
    logic [1:0]         stride_reg;
    logic [CH_W-1:0]    z_last_reg;
    logic [ADDR_W-1:0]  dim_sq_reg, row0_reg, row_step_reg;

    logic [COORD_W-1:0] x_reg, y_reg;
    logic [CH_W-1:0]    z_reg;
    logic [ADDR_W-1:0]  plane_base_reg, row_base_reg;

    logic               inflight_valid_reg, inflight_pad_reg;
    entry_t             inflight_pos_reg;
    entry_t             fifo_mem [2];
    logic               rd_ptr_reg, wr_ptr_reg;
    logic [1:0]         count_reg;
    logic               cfg_err_reg;

    // Start-time products (dim*dim, y_lo*dim, pad*dim) built as shift-add chains.
    logic [ADDR_W-1:0] dim_ext;
    logic [COORD_W:0][ADDR_W-1:0] sq_acc;
    logic [COORD_W:0][ADDR_W-1:0] ylo_acc;
    logic [PAD_W:0][ADDR_W-1:0]   pad_acc;

    assign dim_ext    = ADDR_W'(image_dim);
    assign sq_acc[0]  = '0;
    assign ylo_acc[0] = '0;
    assign pad_acc[0] = '0;

    generate
        for (genvar gi = 0; gi < COORD_W; gi++) begin : g_dim_products
            assign sq_acc[gi+1]  = sq_acc[gi]  + (image_dim[gi] ? (dim_ext << gi) : '0);
            assign ylo_acc[gi+1] = ylo_acc[gi] + (y_lo[gi]      ? (dim_ext << gi) : '0);
        end
        for (genvar gi = 0; gi < PAD_W; gi++) begin : g_pad_product
            assign pad_acc[gi+1] = pad_acc[gi] + (image_padding[gi] ? (dim_ext << gi) : '0);
        end
    endgenerate

    logic [1:0]        stride_init;
    logic [ADDR_W-1:0] row0_init, row_step_init;

    assign stride_init   = (y_stride == 2'd0) ? 2'd1 : y_stride;
    assign row0_init     = ylo_acc[COORD_W] - pad_acc[PAD_W];
    assign row_step_init = (stride_init[0] ? dim_ext : '0) + (stride_init[1] ? (dim_ext << 1) : '0);

    logic cfg_bad, start_ok, pop, issue, in_pad;
    logic row_end, last_row, last_plane, pos_last;
    logic [2:0]         occ;
    logic [COORD_W:0]   pad_lim;
    entry_t             head, push_entry;

    assign cfg_bad  = (x_lo > x_hi) || (y_lo > y_hi);
    assign start_ok = (state_reg == IDLE) && start;

    assign out_valid = (count_reg != 2'd0);
    assign pop       = out_valid && out_ready;
    // Entries already committed to the buffer, minus the one leaving this cycle.
    assign occ       = 3'(count_reg) + 3'(inflight_valid_reg) - 3'(pop);
    assign issue     = (state_reg == RUN) && (occ < 3'd2);

    assign pad_lim = (COORD_W+1)'(dim_reg) + (COORD_W+1)'(pad_reg);
    assign in_pad  = (x_reg < COORD_W'(pad_reg)) || (y_reg < COORD_W'(pad_reg)) ||
                     ({1'b0, x_reg} >= pad_lim) || ({1'b0, y_reg} >= pad_lim);

    assign row_end    = (x_reg == x_hi_reg);
    assign last_row   = ({1'b0, y_reg} + (COORD_W+1)'(stride_reg)) > {1'b0, y_hi_reg};
    assign last_plane = (z_reg == z_last_reg);
    assign pos_last   = row_end && last_row && last_plane;

    assign rd_en   = issue && !in_pad;
    assign rd_addr = rd_en ? (row_base_reg + ADDR_W'(x_reg) - ADDR_W'(pad_reg)) : '0;

    assign head     = fifo_mem[rd_ptr_reg];
    assign out_x    = out_valid ? head.x    : '0;
    assign out_y    = out_valid ? head.y    : '0;
    assign out_z    = out_valid ? head.z    : '0;
    assign out_data = out_valid ? head.data : '0;
    assign out_last = out_valid ? head.last : 1'b0;
    assign cfg_err  = cfg_err_reg;

    always_comb begin
        push_entry      = inflight_pos_reg;
        push_entry.data = inflight_pad_reg ? '0 : rd_data;
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = cfg_bad ? DONE_ERR : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (issue && pos_last) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if ((count_reg == 2'd0) && !inflight_valid_reg) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            DONE_ERR: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= IDLE;
            dim_reg            <= '0;
            x_lo_reg           <= '0;
            x_hi_reg           <= '0;
            y_lo_reg           <= '0;
            y_hi_reg           <= '0;
            pad_reg            <= '0;
            stride_reg         <= 2'd1;
            z_last_reg         <= '0;
            dim_sq_reg         <= '0;
            row0_reg           <= '0;
            row_step_reg       <= '0;
            x_reg              <= '0;
            y_reg              <= '0;
            z_reg              <= '0;
            plane_base_reg     <= '0;
            row_base_reg       <= '0;
            inflight_valid_reg <= 1'b0;
            inflight_pad_reg   <= 1'b0;
            inflight_pos_reg   <= '0;
            for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
            rd_ptr_reg         <= 1'b0;
            wr_ptr_reg         <= 1'b0;
            count_reg          <= 2'd0;
            cfg_err_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (start_ok) begin
                dim_reg        <= image_dim;
                x_lo_reg       <= x_lo;
                x_hi_reg       <= x_hi;
                y_lo_reg       <= y_lo;
                y_hi_reg       <= y_hi;
                pad_reg        <= image_padding;
                stride_reg     <= stride_init;
                z_last_reg     <= z_last;
                dim_sq_reg     <= sq_acc[COORD_W];
                row0_reg       <= row0_init;
                row_step_reg   <= row_step_init;
                x_reg          <= x_lo;
                y_reg          <= y_lo;
                z_reg          <= '0;
                plane_base_reg <= '0;
                row_base_reg   <= row0_init;
                cfg_err_reg    <= cfg_bad;
            end else if (issue) begin
                if (!row_end) begin
                    x_reg <= x_reg + COORD_W'(1);
                end else if (!last_row) begin
                    x_reg        <= x_lo_reg;
                    y_reg        <= y_reg + COORD_W'(stride_reg);
                    row_base_reg <= row_base_reg + row_step_reg;
                end else if (!last_plane) begin
                    x_reg          <= x_lo_reg;
                    y_reg          <= y_lo_reg;
                    z_reg          <= z_reg + CH_W'(1);
                    plane_base_reg <= plane_base_reg + dim_sq_reg;
                    row_base_reg   <= plane_base_reg + dim_sq_reg + row0_reg;
                end
            end

            inflight_valid_reg <= issue;
            inflight_pad_reg   <= in_pad;
            inflight_pos_reg   <= {pos_last, z_reg, y_reg, x_reg, {DATA_W{1'b0}}};

            if (inflight_valid_reg) begin
                fifo_mem[wr_ptr_reg] <= push_entry;
                wr_ptr_reg           <= ~wr_ptr_reg;
            end
            if (pop) rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + 2'(inflight_valid_reg) - 2'(pop);
        end
    end

endmodule
